// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler in front of the elevator car controller.
// Latches floor-button presses, sweeps up/down against the car's current
// floor, drives a one-hot target and holds the door for a fixed dwell.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | no sweep in progress, target parked on current floor
//   MOVE_UP   | heading to the nearest pending floor above the car
//   MOVE_DOWN | heading to the nearest pending floor below the car
//   SERVE     | door open at current floor, dwell counter running
module elevator_request_scheduler #(
    parameter int N_FLOORS     = 4,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] btn,
    input  logic [N_FLOORS-1:0] cur_floor,
    output logic [N_FLOORS-1:0] target,
    output logic [N_FLOORS-1:0] pending,
    output logic                moving_up,
    output logic                moving_down,
    output logic                door_open,
    output logic                fault
);

    localparam int                CW       = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [N_FLOORS-1:0] ONE    = N_FLOORS'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        SERVE     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_FLOORS-1:0] target_q, target_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [N_FLOORS-1:0] btn_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                last_up_q, last_up_d;
    logic                fault_q;

    logic                cur_valid;
    logic [N_FLOORS-1:0] press, clr;
    logic [N_FLOORS-1:0] above, below, here;
    logic [N_FLOORS-1:0] near_above, near_below;

    // Decode of the floor masks; the shift trick relies on cur_floor being one-hot,
    // and the FSM ignores these whenever it is not.
    always_comb begin
        cur_valid  = (cur_floor != '0) && ((cur_floor & (cur_floor - ONE)) == '0);
        below      = pending_q & (cur_floor - ONE);
        above      = pending_q & ~((cur_floor << 1) - ONE);
        here       = pending_q & cur_floor;
        near_above = above & (~above + ONE);
        near_below = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (below[i]) near_below = ONE << i;
        end
        press      = btn & ~btn_q;
        clr        = (state_q == SERVE && cur_valid) ? cur_floor : '0;
        pending_d  = (pending_q | press) & ~clr;
    end

    // Next-state, target and dwell counter; everything holds while cur_floor is invalid.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        last_up_d = last_up_q;
        if (cur_valid) begin
            case (state_q)
                IDLE: begin
                    if (here != '0) begin
                        state_d  = SERVE;
                        target_d = cur_floor;
                        cnt_d    = '0;
                    end else if (above != '0) begin
                        state_d  = MOVE_UP;
                        target_d = near_above;
                    end else if (below != '0) begin
                        state_d  = MOVE_DOWN;
                        target_d = near_below;
                    end else begin
                        target_d = cur_floor;
                    end
                end
                MOVE_UP: begin
                    last_up_d = 1'b1;
                    if (here != '0) begin
                        state_d  = SERVE;
                        target_d = cur_floor;
                        cnt_d    = '0;
                    end else if (above != '0) begin
                        target_d = near_above;
                    end else begin
                        state_d  = IDLE;
                        target_d = cur_floor;
                    end
                end
                MOVE_DOWN: begin
                    last_up_d = 1'b0;
                    if (here != '0) begin
                        state_d  = SERVE;
                        target_d = cur_floor;
                        cnt_d    = '0;
                    end else if (below != '0) begin
                        target_d = near_below;
                    end else begin
                        state_d  = IDLE;
                        target_d = cur_floor;
                    end
                end
                default: begin
                    target_d = cur_floor;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (last_up_q && above != '0) begin
                            state_d  = MOVE_UP;
                            target_d = near_above;
                        end else if (below != '0) begin
                            state_d  = MOVE_DOWN;
                            target_d = near_below;
                        end else if (above != '0) begin
                            state_d  = MOVE_UP;
                            target_d = near_above;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    // State and request registers; btn_q tracks btn through reset so held buttons stay silent.
    always_ff @(posedge clk) begin
        btn_q <= btn;
        if (rst) begin
            state_q   <= IDLE;
            target_q  <= ONE;
            pending_q <= '0;
            cnt_q     <= '0;
            last_up_q <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            last_up_q <= last_up_d;
            fault_q   <= ~cur_valid;
        end
    end

    assign target      = target_q;
    assign pending     = pending_q;
    assign moving_up   = (state_q == MOVE_UP);
    assign moving_down = (state_q == MOVE_DOWN);
    assign door_open   = (state_q == SERVE);
    assign fault       = fault_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler (4 floors, dwell of 4).
// Stimulus pushes expected outputs into a queue; a negedge monitor pops and compares.
module tb_elevator_request_scheduler;

    localparam logic [3:0] F_MU = 4'b1000;
    localparam logic [3:0] F_MD = 4'b0100;
    localparam logic [3:0] F_DR = 4'b0010;
    localparam logic [3:0] F_FT = 4'b0001;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] cur_floor;
    logic [3:0] target;
    logic [3:0] pending;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic       fault;

    typedef struct {
        string      name;
        logic [3:0] tgt;
        logic [3:0] pend;
        logic [3:0] flg;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_err   = 0;
    logic [3:0] act_flg;

    elevator_request_scheduler #(
        .N_FLOORS     (4),
        .DWELL_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .cur_floor   (cur_floor),
        .target      (target),
        .pending     (pending),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks done=%0d", n_total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] tgt,
                              input logic [3:0] pend, input logic [3:0] flg);
        exp_t x;
        x.name = name;
        x.tgt  = tgt;
        x.pend = pend;
        x.flg  = flg;
        sb_q.push_back(x);
    endtask

    task automatic do_reset(input logic [3:0] cf, input logic [3:0] b);
        rst       = 1'b1;
        cur_floor = cf;
        btn       = b;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            act_flg = {moving_up, moving_down, door_open, fault};
            n_total++;
            if (target === e.tgt && pending === e.pend && act_flg === e.flg)
                n_pass++;
            else
                $display("FAIL %s: got target=%b pending=%b up/dn/door/flt=%b, want target=%b pending=%b up/dn/door/flt=%b",
                         e.name, target, pending, act_flg, e.tgt, e.pend, e.flg);
        end
    end

    initial begin
        rst = 1'b1; btn = 4'b0000; cur_floor = 4'b0001;

        // held button through reset, then release and re-press
        do_reset(4'b0001, 4'b0100);
        expect_out("rst_state",     4'b0001, 4'b0000, 4'b0000);
        tick(); expect_out("held_thru_rst", 4'b0001, 4'b0000, 4'b0000);
        btn = 4'b0000; tick(); expect_out("released", 4'b0001, 4'b0000, 4'b0000);
        btn = 4'b0100; tick(); expect_out("repress_pend", 4'b0001, 4'b0100, 4'b0000);
        tick(); expect_out("repress_up", 4'b0100, 4'b0100, F_MU);

        // floor 3 then floor 1 pressed from floor 0
        do_reset(4'b0001, 4'b0000);
        btn = 4'b1000; tick(); expect_out("s2_p3",   4'b0001, 4'b1000, 4'b0000);
        btn = 4'b1010; tick(); expect_out("s2_up3",  4'b1000, 4'b1010, F_MU);
        btn = 4'b0000; tick(); expect_out("s2_up1",  4'b0010, 4'b1010, F_MU);
        cur_floor = 4'b0010;
        tick(); expect_out("s2_arrive", 4'b0010, 4'b1010, F_DR);
        tick(); expect_out("s2_clr",    4'b0010, 4'b1000, F_DR);
        tick(); tick(); expect_out("s2_dwell4", 4'b0010, 4'b1000, F_DR);
        tick(); expect_out("s2_exit_up", 4'b1000, 4'b1000, F_MU);

        // floor 2 served on up sweep with floors 0 and 3 pending: up first
        btn = 4'b0101; cur_floor = 4'b0100;
        tick(); expect_out("s3_pend",   4'b1000, 4'b1101, F_MU);
        btn = 4'b0000;
        tick(); expect_out("s3_serve2", 4'b0100, 4'b1101, F_DR);
        tick(); expect_out("s3_clr2",   4'b0100, 4'b1001, F_DR);
        tick(); tick(); tick(); expect_out("s3_up_first", 4'b1000, 4'b1001, F_MU);
        cur_floor = 4'b1000;
        tick(); expect_out("s3_serve3", 4'b1000, 4'b1001, F_DR);
        tick(); expect_out("s3_clr3",   4'b1000, 4'b0001, F_DR);
        tick(); tick(); tick(); expect_out("s3_down_next", 4'b0001, 4'b0001, F_MD);

        // invalid cur_floor for 3 cycles mid MOVE_DOWN
        cur_floor = 4'b0000;
        tick(); expect_out("s5_fault1", 4'b0001, 4'b0001, F_MD | F_FT);
        btn = 4'b0100;
        tick(); expect_out("s5_fault_press", 4'b0001, 4'b0101, F_MD | F_FT);
        tick(); expect_out("s5_fault3", 4'b0001, 4'b0101, F_MD | F_FT);
        btn = 4'b0000; cur_floor = 4'b0010;
        tick(); expect_out("s5_resume", 4'b0001, 4'b0101, F_MD);
        cur_floor = 4'b0001;
        tick(); expect_out("s5_serve0", 4'b0001, 4'b0101, F_DR);
        tick(); tick(); tick(); tick(); expect_out("s5_turn_up", 4'b0100, 4'b0100, F_MU);

        // press on the current floor from IDLE, re-press during SERVE
        do_reset(4'b0010, 4'b0000);
        btn = 4'b0010; tick(); expect_out("s4_pend",  4'b0010, 4'b0010, 4'b0000);
        tick(); expect_out("s4_serve", 4'b0010, 4'b0010, F_DR);
        btn = 4'b0000; tick(); expect_out("s4_clr",     4'b0010, 4'b0000, F_DR);
        btn = 4'b0010; tick(); expect_out("s4_repress", 4'b0010, 4'b0000, F_DR);
        btn = 4'b0000; tick(); expect_out("s4_dwell4",  4'b0010, 4'b0000, F_DR);
        tick(); expect_out("s4_idle", 4'b0010, 4'b0000, 4'b0000);
        tick(); tick(); expect_out("s4_no_reserve", 4'b0010, 4'b0000, 4'b0000);

        // reset during SERVE with pending requests
        do_reset(4'b0010, 4'b0000);
        btn = 4'b1010; tick(); expect_out("s6_pend",  4'b0010, 4'b1010, 4'b0000);
        tick(); expect_out("s6_serve", 4'b0010, 4'b1010, F_DR);
        rst = 1'b1; btn = 4'b0000;
        tick(); expect_out("s6_rst", 4'b0001, 4'b0000, 4'b0000);
        rst = 1'b0;

        @(negedge clk);
        #1;
        if (target !== 4'b0001 || pending !== 4'b0000 || door_open !== 1'b0) begin
            $display("FAIL s6_after_rst: target=%b pending=%b door_open=%b", target, pending, door_open);
            n_err++;
        end
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard not drained: %0d left", sb_q.size());
            n_err++;
        end
        if (n_total < 12) begin
            $display("FAIL too few checks executed: %0d", n_total);
            n_err++;
        end
        if (n_pass != n_total) begin
            $display("FAIL %0d of %0d checks failed", n_total - n_pass, n_total);
            n_err++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        if (n_err == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Upstream request stage for the elevator car controller. Captures floor-button presses into a pending-request register, runs a SCAN (up/down sweep) scheduler against the car's current floor, and drives a one-hot target floor into the car controller's `floor` input. While the car is at a serviced floor it holds the door open for a fixed dwell, clears that floor's request, then picks the next target.

## Interface
- `N_FLOORS`, default 4: number of floors, which is the width of all floor vectors. Bit 0 is the lowest floor.
- `DWELL_CYCLES`, default 50_000_000: `clk` cycles the door is held open per service. Must be ≥1. The counter width is `$clog2(DWELL_CYCLES+1)`.

Ports:
- `clk`  in  1: system clock, the same undivided clock that feeds the car controller.
- `rst`  in  1: synchronous, active-high reset.
- `btn`  in  N_FLOORS: level-sensitive floor buttons, already synchronous to `clk`. A request is registered on the rising edge of each bit.
- `cur_floor`  in  N_FLOORS: one-hot current floor, driven from the car controller's `y` output.
- `target`  out  N_FLOORS: registered one-hot target floor, driving the car controller's `floor` input.
- `pending`  out  N_FLOORS: registered outstanding requests.
- `moving_up`  out  1: high in state MOVE_UP.
- `moving_down`  out  1: high in state MOVE_DOWN.
- `door_open`  out  1: high in state SERVE.
- `fault`  out  1: high while `cur_floor` is not one-hot (zero or multi-hot).

## Operation
- Edge capture:
  - `btn_q <= btn` every cycle.
  - `press = btn & ~btn_q`.
  - Next pending = `(pending | press) & ~clr`.
  - `clr` = `cur_floor` while in SERVE, otherwise 0. A press on the serviced floor during SERVE is absorbed and never set.
- Helper masks, computed combinationally from `cur_floor`:
  - `above`: pending bits strictly above `cur_floor`.
  - `below`: pending bits strictly below `cur_floor`.
  - `here` = `pending & cur_floor`.
  - nearest-above = lowest set bit of `above`.
  - nearest-below = highest set bit of `below`.
- States: IDLE, MOVE_UP, MOVE_DOWN, SERVE. Register `last_dir` (up/down) records the last sweep direction.
- IDLE (checked in this priority order):
  - `here` ≠ 0 → SERVE.
  - else `above` ≠ 0 → MOVE_UP, `target` = nearest-above.
  - else `below` ≠ 0 → MOVE_DOWN, `target` = nearest-below.
  - else stay in IDLE, `target` = `cur_floor`.
  - When both `above` and `below` are set, up is preferred.
- MOVE_UP:
  - `here` ≠ 0 → SERVE. This covers passing floors with pending requests, not only the target.
  - else `above` ≠ 0 → `target` = nearest-above, recomputed every cycle so new nearer requests are picked up.
  - else → IDLE.
  - Sets `last_dir` = up.
- MOVE_DOWN: mirror image of MOVE_UP, using `below` and nearest-below. Sets `last_dir` = down.
- SERVE:
  - `target` = `cur_floor`.
  - The dwell counter counts from 0 to `DWELL_CYCLES`−1, then the state exits.
  - Exit when `last_dir` = up: `above` → MOVE_UP, else `below` → MOVE_DOWN, else IDLE.
  - Exit when `last_dir` = down: `below` → MOVE_DOWN, else `above` → MOVE_UP, else IDLE.
  - The counter is cleared on SERVE entry.
- Fault: while `cur_floor` is not one-hot:
  - the state, `target`, and dwell counter hold;
  - press capture continues;
  - no `clr` is applied.
  - The FSM resumes on the first valid cycle.
- `target` is always exactly one-hot.

## Timing
- Reset values:
  - `pending` = 0.
  - state = IDLE.
  - `target` = 1 (floor 0, matching the car's reset floor).
  - `moving_up` = `moving_down` = `door_open` = 0.
  - `fault` = 0.
  - dwell counter = 0.
  - `last_dir` = up.
  - `btn_q` loads `btn` during reset, so a button held through reset generates no request.
- Latency:
  - A `btn` rise in cycle t appears in `pending` at t+1.
  - A state or `target` update occurs at t+2.
- Arrival: `cur_floor` matches a pending floor in cycle t → state = SERVE and `door_open` = 1 at t+1. `pending` bit cleared at t+2.
- Dwell: `door_open` is high for exactly `DWELL_CYCLES` cycles. `target` changes in the cycle after `door_open` falls.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset asserted mid-operation: everything returns to reset values on the next edge. Pending requests are discarded.
- The car controller moves slowly (divided clock). `cur_floor` may stay constant for many cycles. The FSM must not re-enter SERVE for a floor already cleared.

## Test plan
All scenarios use `N_FLOORS`=4 and `DWELL_CYCLES`=4.
- Reset with `btn`=4'b0100 held → `pending`=0 and `target`=4'b0001 after release. Releasing and re-pressing `btn`[2] → `pending`=4'b0100, then MOVE_UP with `target`=4'b0100.
- `cur_floor`=0001, press floors 3 then 1 one cycle apart → `target` goes 1000 then 0010. At `cur_floor`=0010: `door_open` high for 4 cycles, `pending`=1000, then `target`=1000 and `moving_up`=1.
- Car at 0100 after an up sweep, `pending`=1001 → SERVE exit goes MOVE_UP to 1000 first, then after service MOVE_DOWN to 0001.
- In IDLE at `cur_floor`=0010, press floor 1 → SERVE for 4 cycles, `pending` returns to 0, then IDLE with `target`=0010. Re-press during SERVE → ignored.
- `cur_floor`=0000 for 3 cycles mid-MOVE_DOWN → `fault`=1, state and `target` frozen. A press during the fault still appears in `pending`. Movement resumes once `cur_floor` is valid.
- Assert `rst` during SERVE with `pending`=1010 → next cycle `pending`=0, `door_open`=0, `target`=0001.
